// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: fetch PC, BRAM address, 1-entry skid, redirect flush
// Optional fetch-fault tagging is enabled by defining FETCH_FAULT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          IMEM_ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        infl_v_q, infl_v_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        infl_fault_q, infl_fault_d;
  logic        sk_v_q, sk_v_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic        sk_fault_q, sk_fault_d;
  logic        out_v_q, out_v_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_fault_q, out_fault_d;

  logic        issue;
  logic        accept;
  logic [31:0] issue_pc;
  logic        issue_fault;
  logic [31:0] ret_instr;
  logic        unused_fault_bits;

  always_comb begin
    issue    = redirect_valid | (!sk_v_q & !(out_v_q & stall_id & infl_v_q));
    accept   = !out_v_q | !stall_id;
    issue_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : {fetch_pc_q[31:2], 2'b00};
    // The BRAM sees the reset PC while reset is held, whatever redirect is doing.
    imem_addr = rst ? RESET_PC[31:2] : issue_pc[31:2];
    unused_fault_bits = ^{redirect_pc[1:0], issue_pc[31:IMEM_ADDR_BITS]};
`ifdef FETCH_FAULT_EN
    issue_fault = (issue_pc[31:IMEM_ADDR_BITS] != '0) | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    ret_instr   = infl_fault_q ? 32'h0000_0013 : imem_rdata;
`else
    issue_fault = 1'b0;
    ret_instr   = imem_rdata;
`endif
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    infl_v_d     = 1'b0;
    infl_pc_d    = infl_pc_q;
    infl_fault_d = infl_fault_q;
    sk_v_d       = sk_v_q;
    sk_pc_d      = sk_pc_q;
    sk_instr_d   = sk_instr_q;
    sk_fault_d   = sk_fault_q;
    out_v_d      = out_v_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_fault_d  = out_fault_q;

    if (issue) begin
      infl_v_d     = 1'b1;
      infl_pc_d    = issue_pc;
      infl_fault_d = issue_fault;
      fetch_pc_d   = issue_pc + 32'd4;
    end

    if (redirect_valid) begin
      out_v_d = 1'b0;
      sk_v_d  = 1'b0;
    end else if (accept) begin
      if (sk_v_q) begin
        out_v_d     = 1'b1;
        out_pc_d    = sk_pc_q;
        out_instr_d = sk_instr_q;
        out_fault_d = sk_fault_q;
        sk_v_d      = infl_v_q;
        if (infl_v_q) begin
          sk_pc_d    = infl_pc_q;
          sk_instr_d = ret_instr;
          sk_fault_d = infl_fault_q;
        end
      end else begin
        out_v_d = infl_v_q;
        if (infl_v_q) begin
          out_pc_d    = infl_pc_q;
          out_instr_d = ret_instr;
          out_fault_d = infl_fault_q;
        end
      end
    end else if (infl_v_q) begin
      // Output is stalled: park the returning word, the BRAM will not hold it.
      sk_v_d     = 1'b1;
      sk_pc_d    = infl_pc_q;
      sk_instr_d = ret_instr;
      sk_fault_d = infl_fault_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      infl_v_q     <= 1'b0;
      infl_pc_q    <= 32'h0;
      infl_fault_q <= 1'b0;
      sk_v_q       <= 1'b0;
      sk_pc_q      <= 32'h0;
      sk_instr_q   <= 32'h0;
      sk_fault_q   <= 1'b0;
      out_v_q      <= 1'b0;
      out_pc_q     <= 32'h0;
      out_instr_q  <= 32'h0;
      out_fault_q  <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      infl_v_q     <= infl_v_d;
      infl_pc_q    <= infl_pc_d;
      infl_fault_q <= infl_fault_d;
      sk_v_q       <= sk_v_d;
      sk_pc_q      <= sk_pc_d;
      sk_instr_q   <= sk_instr_d;
      sk_fault_q   <= sk_fault_d;
      out_v_q      <= out_v_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_fault_q  <= out_fault_d;
    end
  end

  assign if_valid = out_v_q;
  assign if_pc    = out_pc_q;
  assign if_instr = out_instr_q;
  assign if_fault = out_fault_q;

endmodule
